pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central stall/flush scheduler for the 5-stage pipeline. It sits beside the instruction decoder, sees the ID-stage opcode and source registers plus the EXE/MEM destination fields, and drives the PC/IF-ID hold, ID-EXE bubble and IF-ID flush controls. It also sequences the two-phase SWP instruction and freezes the whole pipeline while data memory is not ready. It replaces the ad-hoc freeze logic previously embedded in decode.

## Interface
- CNT_W, 16, width of the saturating stall-cycle counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_opcode  in  6  opcode of instruction in ID
- id_src1, id_src2  in  5 each  ID source registers
- id_single_src  in  1  ID uses src1 only
- exe_dest, mem_dest  in  5 each  destination registers in EXE / MEM
- exe_wb_en, mem_wb_en  in  1 each  writeback enables in EXE / MEM
- exe_mem_r_en  in  1  EXE instruction is LD
- branch_taken  in  1  branch resolved taken in EXE
- mem_req  in  1  MEM stage issues a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- freeze_pc  out  1  hold PC and IF/ID register
- bubble_exe  out  1  load NOP into ID/EXE register
- flush_id  out  1  clear IF/ID register to NOP
- freeze_all  out  1  hold every pipeline register
- swp_phase  out  2  00 none, 01 SWP first half, 10 SWP second half
- stall_cycles  out  CNT_W  saturating count of cycles with freeze_pc or freeze_all high

## Operation
- States: RUN, SWP2, MEM_WAIT. A ret_state register holds RUN or SWP2 for MEM_WAIT exit.
- Register 0 never causes a hazard. id_src2 is compared only when id_single_src=0.
- Hazard (hz): a source matches exe_dest with exe_wb_en=1, or matches mem_dest with mem_wb_en=1. The FORWARDING_EN macro redefines it; see Configuration.
- Priority within a cycle, highest first: rst, mem wait, branch_taken, hz, SWP.
- Any state, mem_req=1 and mem_ready=0:
  - freeze_all=1; all other outputs 0, except swp_phase, which keeps its current-state value.
  - Go to MEM_WAIT and save the current state (or the saved state, if already in MEM_WAIT) into ret_state.
- MEM_WAIT with mem_ready=1: leave freeze_all low and evaluate the ret_state rules in this same cycle.
- RUN:
  - branch_taken=1: flush_id=1, bubble_exe=1, swp_phase=00; stay in RUN.
  - Else hz=1: freeze_pc=1, bubble_exe=1.
  - Else id_opcode=6'b111111 (SWP): swp_phase=01, freeze_pc=1; next state SWP2.
  - Otherwise all outputs 0.
- SWP2:
  - swp_phase=10, freeze_pc=0; next state RUN.
  - branch_taken=1 (illegal here): treat as a RUN flush, swp_phase=00, go to RUN.
- Hazard is not evaluated in SWP2. The first half has already committed the operands.
- stall_cycles increments when freeze_pc|freeze_all is high, saturates at all-ones, and clears on rst.

## Timing
- All outputs are combinational from state and inputs. No added latency: the hazard seen in cycle N stalls cycle N.
- State, ret_state and stall_cycles update on the rising clk edge.
- rst high: the next edge gives state=RUN, ret_state=RUN, stall_cycles=0. While rst is high, all outputs are forced to 0.
- rst mid-SWP or mid-MEM_WAIT aborts with no residual phase.
- SWP occupies exactly 2 ID cycles (01 then 10), plus any MEM_WAIT cycles inserted between them.
- Load-use stall is 1 cycle with forwarding. Without forwarding, a RAW stall lasts up to 2 cycles.
- mem_ready=1 in the same cycle as mem_req: no wait, no state change.

## Configuration
- Macro: PIPELINE_SEQUENCER_FORWARDING_EN.
- Defined: hz is only exe_mem_r_en=1 with an exe_dest match (load-use). MEM-stage and ALU-result matches are forwarded and cause no stall.
- Undefined: hz is the full EXE/MEM match rule above.

## Test plan
- RAW, macro off: exe_dest=3, exe_wb_en=1, id_src1=3 -> freeze_pc=1 and bubble_exe=1 for 1 cycle. The match moves to mem_dest and stalls again. Total 2 stall cycles; stall_cycles=2.
- Load-use, macro on: exe_mem_r_en=1, exe_dest=5, id_src2=5, id_single_src=0 -> exactly 1 stall cycle. The same with exe_mem_r_en=0 -> no stall.
- SWP: id_opcode=6'b111111, no hazard -> cycle 1 swp_phase=01 with freeze_pc=1; cycle 2 swp_phase=10 with freeze_pc=0; cycle 3 back to RUN, swp_phase=00.
- Mem wait inside SWP: after phase 01, mem_req=1 and mem_ready=0 for 3 cycles -> freeze_all=1 for 3 cycles with swp_phase=01. On mem_ready=1, swp_phase=10 that cycle; stall_cycles=4.
- Branch vs hazard: branch_taken=1 while a hazard is present and id_opcode=SWP -> flush_id=1, bubble_exe=1, freeze_pc=0, swp_phase=00, state stays RUN.
- Reset: rst asserted in MEM_WAIT with counter at 7 -> all outputs 0. Next edge: RUN, stall_cycles=0. Counter forced to 2^CNT_W-1 holds at that value under further stalls.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - pipeline stage fields in, stall/flush/freeze controls out
interface pipeline_sequencer_if #(parameter int CNT_W = 16);
  logic [5:0]       id_opcode;
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_single_src;
  logic [4:0]       exe_dest;
  logic [4:0]       mem_dest;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic             exe_mem_r_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_pc;
  logic             bubble_exe;
  logic             flush_id;
  logic             freeze_all;
  logic [1:0]       swp_phase;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_opcode, id_src1, id_src2, id_single_src, exe_dest, mem_dest,
           exe_wb_en, mem_wb_en, exe_mem_r_en, branch_taken, mem_req, mem_ready,
    input  freeze_pc, bubble_exe, flush_id, freeze_all, swp_phase, stall_cycles
  );

  modport slave (
    input  id_opcode, id_src1, id_src2, id_single_src, exe_dest, mem_dest,
           exe_wb_en, mem_wb_en, exe_mem_r_en, branch_taken, mem_req, mem_ready,
    output freeze_pc, bubble_exe, flush_id, freeze_all, swp_phase, stall_cycles
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush scheduler with SWP sequencing and memory-wait freeze
// Optional macro PIPELINE_SEQUENCER_FORWARDING_EN: only load-use matches stall.
module pipeline_sequencer #(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {RUN, SWP2, MEM_WAIT} state_t;

  localparam logic [5:0] OP_SWP = 6'b111111;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic freeze_pc, bubble_exe, flush_id, freeze_all;
  logic [1:0] swp_phase;
  logic src1_live, src2_live, hz, mem_stall;

  assign src1_live = (bus.id_src1 != 5'd0);
  assign src2_live = (bus.id_src2 != 5'd0) && !bus.id_single_src;

`ifdef PIPELINE_SEQUENCER_FORWARDING_EN
  assign hz = bus.exe_mem_r_en &&
              ((src1_live && bus.id_src1 == bus.exe_dest) ||
               (src2_live && bus.id_src2 == bus.exe_dest));
`else
  assign hz = (src1_live && ((bus.exe_wb_en && bus.id_src1 == bus.exe_dest) ||
                             (bus.mem_wb_en && bus.id_src1 == bus.mem_dest))) ||
              (src2_live && ((bus.exe_wb_en && bus.id_src2 == bus.exe_dest) ||
                             (bus.mem_wb_en && bus.id_src2 == bus.mem_dest)));
`endif

  assign mem_stall = bus.mem_req && !bus.mem_ready;
  // MEM_WAIT acts on behalf of the state it interrupted
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d    = RUN;
    ret_d      = ret_q;
    freeze_pc  = 1'b0;
    bubble_exe = 1'b0;
    flush_id   = 1'b0;
    freeze_all = 1'b0;
    swp_phase  = 2'b00;
    if (rst) begin
      state_d = RUN;
      ret_d   = RUN;
    end else if (mem_stall) begin
      freeze_all = 1'b1;
      swp_phase  = (eff_state == SWP2) ? 2'b01 : 2'b00;
      state_d    = MEM_WAIT;
      ret_d      = eff_state;
    end else if (eff_state == SWP2) begin
      if (bus.branch_taken) begin
        flush_id   = 1'b1;
        bubble_exe = 1'b1;
      end else begin
        swp_phase = 2'b10;
      end
    end else begin
      if (bus.branch_taken) begin
        flush_id   = 1'b1;
        bubble_exe = 1'b1;
      end else if (hz) begin
        freeze_pc  = 1'b1;
        bubble_exe = 1'b1;
      end else if (bus.id_opcode == OP_SWP) begin
        swp_phase = 2'b01;
        freeze_pc = 1'b1;
        state_d   = SWP2;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((freeze_pc || freeze_all) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.freeze_pc    = freeze_pc;
  assign bus.bubble_exe   = bubble_exe;
  assign bus.flush_id     = flush_id;
  assign bus.freeze_all   = freeze_all;
  assign bus.swp_phase    = swp_phase;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed checks of stalls, SWP sequencing, memory wait and reset
module tb_pipeline_sequencer;
  localparam int CNT_W = 4;
`ifdef PIPELINE_SEQUENCER_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  logic [5:0] obs;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pipeline_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {freeze_pc, bubble_exe, flush_id, freeze_all, swp_phase}
  assign obs = {bus.freeze_pc, bus.bubble_exe, bus.flush_id, bus.freeze_all, bus.swp_phase};

  task automatic set_idle();
    bus.id_opcode = 6'd0; bus.id_src1 = 5'd0; bus.id_src2 = 5'd0; bus.id_single_src = 1'b1;
    bus.exe_dest = 5'd0; bus.mem_dest = 5'd0; bus.exe_wb_en = 1'b0; bus.mem_wb_en = 1'b0;
    bus.exe_mem_r_en = 1'b0; bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; set_idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; set_idle();
    bus.id_src1 = 5'd3; bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b1; bus.id_opcode = 6'h3f;
    bus.mem_req = 1'b1;
    #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL reset_outputs got %b want %b", obs, 6'b000000); else n_pass++;
    @(negedge clk); set_idle(); #1;
    n_total++;
    if (bus.stall_cycles !== 4'd0) $display("FAIL reset_count got %0d want 0", bus.stall_cycles); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_raw();
    do_reset();
    @(negedge clk); bus.id_src1 = 5'd3; bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b1; #1;
    n_total++;
    if (obs !== (FWD ? 6'b000000 : 6'b110000)) $display("FAIL raw_exe got %b", obs); else n_pass++;
    @(negedge clk); bus.exe_wb_en = 1'b0; bus.mem_dest = 5'd3; bus.mem_wb_en = 1'b1; #1;
    n_total++;
    if (obs !== (FWD ? 6'b000000 : 6'b110000)) $display("FAIL raw_mem got %b", obs); else n_pass++;
    @(negedge clk); bus.mem_wb_en = 1'b0; #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL raw_clear got %b want 000000", obs); else n_pass++;
    n_total++;
    if (bus.stall_cycles !== (FWD ? 4'd0 : 4'd2)) $display("FAIL raw_count got %0d", bus.stall_cycles); else n_pass++;
    // register 0 and single-source masking never stall
    @(negedge clk); set_idle(); bus.exe_dest = 5'd0; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1; #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL reg0 got %b want 000000", obs); else n_pass++;
    @(negedge clk); bus.id_src1 = 5'd1; bus.id_src2 = 5'd9; bus.exe_dest = 5'd9; bus.id_single_src = 1'b1; #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL single_src got %b want 000000", obs); else n_pass++;
    @(negedge clk); bus.id_single_src = 1'b0; #1;
    n_total++;
    if (obs !== 6'b110000) $display("FAIL src2_hz got %b want 110000", obs); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); bus.exe_mem_r_en = 1'b1; bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd5;
    bus.id_src1 = 5'd7; bus.id_src2 = 5'd5; bus.id_single_src = 1'b0; #1;
    n_total++;
    if (obs !== 6'b110000) $display("FAIL ld_use got %b want 110000", obs); else n_pass++;
    @(negedge clk); bus.exe_mem_r_en = 1'b0; bus.exe_wb_en = 1'b0;
    bus.mem_dest = 5'd5; bus.mem_wb_en = 1'b1; #1;
    n_total++;
    if (obs !== (FWD ? 6'b000000 : 6'b110000)) $display("FAIL ld_mem got %b", obs); else n_pass++;
    @(negedge clk); bus.mem_wb_en = 1'b0; bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd5; #1;
    n_total++;
    if (obs !== (FWD ? 6'b000000 : 6'b110000)) $display("FAIL alu_exe got %b", obs); else n_pass++;
  endtask

  task automatic test_swp();
    do_reset();
    @(negedge clk); bus.id_opcode = 6'h3f; #1;
    n_total++;
    if (obs !== 6'b100001) $display("FAIL swp_p1 got %b want 100001", obs); else n_pass++;
    @(negedge clk); bus.id_opcode = 6'h00; #1;
    n_total++;
    if (obs !== 6'b000010) $display("FAIL swp_p2 got %b want 000010", obs); else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL swp_done got %b want 000000", obs); else n_pass++;
    n_total++;
    if (bus.stall_cycles !== 4'd1) $display("FAIL swp_count got %0d want 1", bus.stall_cycles); else n_pass++;
  endtask

  task automatic test_swp_mem_wait();
    do_reset();
    @(negedge clk); bus.id_opcode = 6'h3f; #1;
    n_total++;
    if (obs !== 6'b100001) $display("FAIL swpw_p1 got %b want 100001", obs); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.id_opcode = 6'h00; bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
      n_total++;
      if (obs !== 6'b000101) $display("FAIL swpw_wait%0d got %b want 000101", i, obs); else n_pass++;
    end
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    n_total++;
    if (obs !== 6'b000010) $display("FAIL swpw_p2 got %b want 000010", obs); else n_pass++;
    @(negedge clk); set_idle(); #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL swpw_done got %b want 000000", obs); else n_pass++;
    n_total++;
    if (bus.stall_cycles !== 4'd4) $display("FAIL swpw_count got %0d want 4", bus.stall_cycles); else n_pass++;
    @(negedge clk); bus.mem_req = 1'b1; bus.mem_ready = 1'b1; #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL mem_ready_now got %b want 000000", obs); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk); bus.branch_taken = 1'b1; bus.id_opcode = 6'h3f;
    bus.id_src1 = 5'd4; bus.exe_dest = 5'd4; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1; #1;
    n_total++;
    if (obs !== 6'b011000) $display("FAIL br_hz got %b want 011000", obs); else n_pass++;
    @(negedge clk); set_idle(); #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL br_after got %b want 000000", obs); else n_pass++;
    @(negedge clk); bus.id_opcode = 6'h3f; #1;
    @(negedge clk); bus.id_opcode = 6'h00; bus.branch_taken = 1'b1; #1;
    n_total++;
    if (obs !== 6'b011000) $display("FAIL br_swp2 got %b want 011000", obs); else n_pass++;
    @(negedge clk); set_idle(); #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL br_swp2_after got %b want 000000", obs); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    end
    @(negedge clk); #1;
    n_total++;
    if (bus.stall_cycles !== 4'd7) $display("FAIL mw_count got %0d want 7", bus.stall_cycles); else n_pass++;
    rst = 1'b1; #1;
    n_total++;
    if (obs !== 6'b000000) $display("FAIL mw_rst_out got %b want 000000", obs); else n_pass++;
    @(negedge clk); rst = 1'b0; set_idle(); bus.id_opcode = 6'h3f; #1;
    n_total++;
    if (bus.stall_cycles !== 4'd0) $display("FAIL mw_rst_count got %0d want 0", bus.stall_cycles); else n_pass++;
    n_total++;
    if (obs !== 6'b100001) $display("FAIL mw_rst_run got %b want 100001", obs); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); bus.id_src1 = 5'd2; bus.exe_dest = 5'd2; bus.exe_wb_en = 1'b1;
      bus.exe_mem_r_en = 1'b1; #1;
      if (i == 14 || i == 16) begin
        n_total++;
        if (bus.stall_cycles !== (i == 14 ? 4'd14 : 4'd15))
          $display("FAIL sat_count%0d got %0d", i, bus.stall_cycles);
        else n_pass++;
      end
    end
    @(negedge clk); #1;
    n_total++;
    if (bus.stall_cycles !== 4'd15) $display("FAIL sat_hold got %0d want 15", bus.stall_cycles); else n_pass++;
    n_total++;
    if (obs !== 6'b110000) $display("FAIL sat_out got %b want 110000", obs); else n_pass++;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_raw();
    test_load_use();
    test_swp();
    test_swp_mem_wait();
    test_branch();
    test_reset_mid_wait();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
